pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core (IF, ID, EX, MEN, WB). It keeps a shadow scoreboard of destination registers for instructions in EX, MEN and WB. From that scoreboard it drives hold, flush and bubble controls to PC and to the IF_ID, ID_EX, EX_MEN and MEN_WB registers, and it drives the ID-stage operand forwarding selects. It also freezes the pipe while a multi-cycle data-memory access through the bridge is outstanding, and it counts stall and flush cycles.

---
 rtl/pipe_ctrl_pkg.sv | 62 ++++++
 rtl/hazard_shadow.sv | 62 ++++++
 rtl/pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the 5-stage pipeline hazard controller:
//   - forwarding-select encodings for the ID operand muxes
//   - FSM state encoding for the data-memory wait tracker
//   - the shadow scoreboard entry {rd, we, ld}
//   - fwd_lookup(): per-operand forwarding / load-use resolution
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // ID operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_EX  = 2'b01;  // ex_wd
  localparam logic [1:0] FWD_MEN = 2'b10;  // men_wd
  localparam logic [1:0] FWD_WB  = 2'b11;  // wb_wD

  // Memory-wait FSM encoding.
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // One scoreboard slot: destination, writes-RF flag, data-comes-from-DRAM flag.
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // Result of resolving one source operand against the scoreboard.
  typedef struct packed {
    logic       load_use;  // operand depends on a load still in EX
    logic [1:0] sel;       // forwarding select
  } fwd_result_t;

  // Youngest producer wins: EX, then MEN, then WB, otherwise the RF value is
  // already current. A load in EX has no data yet, so it cannot forward and
  // must stall the consumer for one cycle instead.
  function automatic fwd_result_t fwd_lookup(
    input logic          used,
    input logic [4:0]    rs,
    input shadow_entry_t ex_e,
    input shadow_entry_t men_e,
    input shadow_entry_t wb_e
  );
    fwd_result_t r;
    r.load_use = 1'b0;
    r.sel      = FWD_RF;
    if (used && (rs != 5'd0)) begin
      if (ex_e.we && (ex_e.rd == rs)) begin
        if (ex_e.ld) r.load_use = 1'b1;
        else         r.sel      = FWD_EX;
      end else if (men_e.we && (men_e.rd == rs)) begin
        r.sel = FWD_MEN;
      end else if (wb_e.we && (wb_e.rd == rs)) begin
        r.sel = FWD_WB;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_shadow.sv
// -----------------------------------------------------------------------------
// hazard_shadow
//   Three-entry shadow scoreboard that mirrors the destination registers of
//   the instructions sitting in EX, MEN and WB.
//
//   Ports:
//     cpu_clk    in  : clock, rising edge
//     cpu_rst    in  : asynchronous active-low reset (all entries -> bubble)
//     advance    in  : pipe moves one stage this cycle
//     freeze     in  : pipe is frozen on a DRAM wait (wins over advance)
//     ex_bubble  in  : EX receives a bubble instead of the ID instruction
//     id_entry   in  : {rd, we, ld} of the instruction leaving ID
//     ex_entry   out : scoreboard slot for EX
//     men_entry  out : scoreboard slot for MEN
//     wb_entry   out : scoreboard slot for WB
// -----------------------------------------------------------------------------
module hazard_shadow
  import pipe_ctrl_pkg::*;
(
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  input  logic          advance,
  input  logic          freeze,
  input  logic          ex_bubble,
  input  shadow_entry_t id_entry,
  output shadow_entry_t ex_entry,
  output shadow_entry_t men_entry,
  output shadow_entry_t wb_entry
);

  shadow_entry_t id_clean;

  // x0 is hardwired to zero, so a write to it is never a real producer.
  // NOTE: every output of a combinational block gets a default assignment
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    id_clean = id_entry;
    if (id_entry.rd == 5'd0) id_clean.we = 1'b0;
  end

  // NOTE: the scoreboard is three small control registers, not a storage
  // array, so it is reset like any other state; a stale we=1 after reset
  // would create phantom hazards.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      // NOTE: state uses non-blocking assignments so that the shift
      // WB<-MEN<-EX below samples the pre-edge values of every slot.
      ex_entry  <= SHADOW_BUBBLE;
      men_entry <= SHADOW_BUBBLE;
      wb_entry  <= SHADOW_BUBBLE;
    end else if (freeze) begin
      // EX and MEN keep their instructions; MEN_WB is loaded with a bubble,
      // so the WB slot drains while the pipe waits on DRAM.
      wb_entry <= SHADOW_BUBBLE;
    end else if (advance) begin
      wb_entry  <= men_entry;
      men_entry <= ex_entry;
      ex_entry  <= ex_bubble ? SHADOW_BUBBLE : id_clean;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Sequencing controller for the 5-stage RISC-V pipe (IF, ID, EX, MEN, WB).
//   Drives hold / flush / bubble controls, the ID operand forwarding selects,
//   freezes the pipe during multi-cycle DRAM accesses, and counts stall and
//   flush cycles.
//
//   Parameters:
//     CNT_W          : width of the saturating performance counters
//
//   Ports:
//     cpu_clk        in  : clock, rising edge
//     cpu_rst        in  : asynchronous active-low reset
//     id_valid       in  : ID holds a real instruction
//     id_rs1/id_rs2  in  : ID source register indices
//     id_rs1_used/id_rs2_used in : ID instruction reads rs1 / rs2
//     id_rd          in  : ID destination register
//     id_rf_we       in  : ID instruction writes the RF
//     id_is_load     in  : ID instruction writeback data comes from DRAM
//     ex_br_taken    in  : EX redirects the PC
//     mem_req        in  : MEN performs a DRAM access this cycle
//     mem_ready      in  : bridge completes the access this cycle
//     pc_hold, if_id_hold, id_ex_hold, ex_mem_hold  out : register keeps value
//     if_id_flush, id_ex_flush                      out : register loads bubble
//     mem_wb_bubble  out : MEN_WB loads rf_we=0
//     fwd_a_sel/fwd_b_sel out : ID operand source (RF/EX/MEN/WB)
//     stall_cnt/flush_cnt out : saturating event counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // ---------------------------------------------------------------------------
  // Memory-wait FSM
  // ---------------------------------------------------------------------------
  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       frozen;

  always_comb begin
    state_d = state_q;
    frozen  = 1'b0;
    case (state_q)
      ST_RUN: begin
        // mem_ready without mem_req is meaningless here and is ignored; a
        // request answered in the same cycle completes with zero wait.
        frozen = mem_req & ~mem_ready;
        if (mem_req && !mem_ready) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        frozen = ~mem_ready;
        if (mem_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and operand resolution
  // ---------------------------------------------------------------------------
  shadow_entry_t ex_entry;
  shadow_entry_t men_entry;
  shadow_entry_t wb_entry;
  shadow_entry_t id_entry;
  fwd_result_t   res_a;
  fwd_result_t   res_b;
  logic          load_use;
  logic          branch_flush;
  logic          ex_bubble;

  always_comb begin
    id_entry.rd = id_rd;
    id_entry.we = id_rf_we & id_valid;
    id_entry.ld = id_is_load;
    // A bubble in ID reads nothing, so it can neither forward nor stall.
    res_a = fwd_lookup(id_valid & id_rs1_used, id_rs1, ex_entry, men_entry, wb_entry);
    res_b = fwd_lookup(id_valid & id_rs2_used, id_rs2, ex_entry, men_entry, wb_entry);
    // While frozen the load in EX is not moving either, so there is nothing
    // to resolve until the pipe runs again.
    load_use     = (res_a.load_use | res_b.load_use) & ~frozen;
    branch_flush = ex_br_taken & ~frozen;
    // Either a redirect or a load-use stall sends a bubble into ID_EX.
    ex_bubble    = branch_flush | load_use;
  end

  hazard_shadow u_shadow (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .advance   (~frozen),
    .freeze    (frozen),
    .ex_bubble (ex_bubble),
    .id_entry  (id_entry),
    .ex_entry  (ex_entry),
    .men_entry (men_entry),
    .wb_entry  (wb_entry)
  );

  // ---------------------------------------------------------------------------
  // Pipeline controls: freeze > branch flush > load-use
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    fwd_a_sel     = res_a.sel;
    fwd_b_sel     = res_b.sel;

    if (frozen) begin
      // Everything upstream of MEN waits; WB must not re-commit, so MEN_WB
      // gets a bubble. A taken branch in EX is simply held until release.
      pc_hold       = 1'b1;
      if_id_hold    = 1'b1;
      id_ex_hold    = 1'b1;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (branch_flush) begin
      // The ID instruction is wrong-path, so any load-use on it is moot and
      // the PC is free to take the redirect.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      id_ex_flush = 1'b1;
    end

    // Outputs go quiet the moment reset asserts, independent of the inputs
    // and without waiting for a clock edge.
    if (!cpu_rst) begin
      pc_hold       = 1'b0;
      if_id_hold    = 1'b0;
      id_ex_hold    = 1'b0;
      ex_mem_hold   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
      fwd_a_sel     = FWD_RF;
      fwd_b_sel     = FWD_RF;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((frozen || load_use) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Inputs change on the falling edge;
//   each step pushes its expected output vector to a scoreboard queue, then
//   pops and compares it 2 ns later, well before the next rising edge.
//   Counter width is shrunk to 4 bits so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          id_valid;
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [4:0]    id_rd;
  logic          id_rf_we;
  logic          id_is_load;
  logic          ex_br_taken;
  logic          mem_req;
  logic          mem_ready;
  logic          pc_hold;
  logic          if_id_hold;
  logic          id_ex_hold;
  logic          ex_mem_hold;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          mem_wb_bubble;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .id_rd         (id_rd),
    .id_rf_we      (id_rf_we),
    .id_is_load    (id_is_load),
    .ex_br_taken   (ex_br_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_hold       (pc_hold),
    .if_id_hold    (if_id_hold),
    .id_ex_hold    (id_ex_hold),
    .ex_mem_hold   (ex_mem_hold),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .mem_wb_bubble (mem_wb_bubble),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Observed vector: {pc,if_id,id_ex,ex_mem holds | if_id,id_ex flush |
  //                   mem_wb_bubble | fwd_a | fwd_b | stall_cnt | flush_cnt}
  localparam int VW = 4 + 2 + 1 + 2 + 2 + CW + CW;
  logic [VW-1:0] obs;
  assign obs = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
                if_id_flush, id_ex_flush, mem_wb_bubble,
                fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt};

  typedef struct {
    string         tag;
    logic [VW-1:0] vec;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [VW-1:0] ev(
    input logic [3:0]    h,
    input logic [1:0]    f,
    input logic          b,
    input logic [1:0]    fa,
    input logic [1:0]    fb,
    input logic [CW-1:0] sc,
    input logic [CW-1:0] fc
  );
    return {h, f, b, fa, fb, sc, fc};
  endfunction

  task automatic expect_now(input string tag, input logic [VW-1:0] v);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.vec = v;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    vectors++;
    assert (obs === got.vec) else begin
      miscompares++;
      $error("FAIL %s: observed %b required %b", got.tag, obs, got.vec);
    end
  endtask

  task automatic step(input string tag, input logic [VW-1:0] v);
    expect_now(tag, v);
    @(negedge cpu_clk);
  endtask

  task automatic set_id(
    input logic       v,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       u1,
    input logic       u2,
    input logic [4:0] rd,
    input logic       we,
    input logic       ld
  );
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd       = rd;
    id_rf_we    = we;
    id_is_load  = ld;
  endtask

  initial begin
    int e_sc;
    cpu_rst     = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_br_taken = 1'b0;
    mem_req     = 1'b0;
    mem_ready   = 1'b0;
    #1;
    // Reset with hazard-causing inputs present: outputs must still be zero.
    cpu_rst     = 1'b0;
    mem_req     = 1'b1;
    ex_br_taken = 1'b1;
    expect_now("reset_outputs", ev(0, 0, 0, 0, 0, 0, 0));
    @(negedge cpu_clk);
    mem_req     = 1'b0;
    ex_br_taken = 1'b0;
    cpu_rst     = 1'b1;
    step("idle_after_reset", ev(0, 0, 0, 0, 0, 0, 0));

    // Forwarding priority as a rd=5 writer walks EX -> MEN -> WB.
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    step("issue_rd5", ev(0, 0, 0, 0, 0, 0, 0));
    set_id(1, 5, 5, 1, 1, 0, 0, 0);
    step("fwd_ex_both", ev(0, 0, 0, 2'b01, 2'b01, 0, 0));
    step("fwd_men_both", ev(0, 0, 0, 2'b10, 2'b10, 0, 0));
    step("fwd_wb_both", ev(0, 0, 0, 2'b11, 2'b11, 0, 0));
    step("fwd_rf_drained", ev(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // Two rd=6 writers back to back: younger one wins; unused rs2 ignored.
    set_id(1, 0, 0, 0, 0, 6, 1, 0);
    step("issue_rd6_a", ev(0, 0, 0, 0, 0, 0, 0));
    set_id(1, 6, 0, 1, 0, 6, 1, 0);
    step("fwd_ex_rd6", ev(0, 0, 0, 2'b01, 2'b00, 0, 0));
    set_id(1, 6, 6, 1, 0, 0, 0, 0);
    step("fwd_ex_over_men", ev(0, 0, 0, 2'b01, 2'b00, 0, 0));
    set_id(1, 6, 0, 1, 0, 0, 0, 0);
    step("fwd_men_over_wb", ev(0, 0, 0, 2'b10, 2'b00, 0, 0));
    step("fwd_wb_rd6", ev(0, 0, 0, 2'b11, 2'b00, 0, 0));
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step("drain_a", ev(0, 0, 0, 0, 0, 0, 0));

    // Load-use: lw x7 then add reading x7 on rs2.
    set_id(1, 0, 0, 0, 0, 7, 1, 1);
    step("issue_lw_x7", ev(0, 0, 0, 0, 0, 0, 0));
    set_id(1, 3, 7, 1, 1, 8, 1, 0);
    step("load_use_stall", ev(4'b1100, 2'b01, 0, 2'b00, 2'b00, 0, 0));
    step("load_use_men_fwd", ev(0, 0, 0, 2'b00, 2'b10, 1, 0));
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step("after_load_use", ev(0, 0, 0, 0, 0, 1, 0));
    step("drain_b1", ev(0, 0, 0, 0, 0, 1, 0));
    step("drain_b2", ev(0, 0, 0, 0, 0, 1, 0));

    // Branch in the same cycle as a load-use: flush wins, EX gets a bubble.
    set_id(1, 0, 0, 0, 0, 9, 1, 1);
    step("issue_lw_x9", ev(0, 0, 0, 0, 0, 1, 0));
    set_id(1, 9, 0, 1, 0, 10, 1, 0);
    ex_br_taken = 1'b1;
    step("branch_over_load_use", ev(0, 2'b11, 0, 2'b00, 2'b00, 1, 0));
    ex_br_taken = 1'b0;
    set_id(1, 10, 0, 1, 0, 0, 0, 0);
    step("ex_bubble_after_branch", ev(0, 0, 0, 2'b00, 2'b00, 2, 1));
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step("drain_c1", ev(0, 0, 0, 0, 0, 2, 1));
    step("drain_c2", ev(0, 0, 0, 0, 0, 2, 1));

    // Three-cycle DRAM wait, then ready.
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    step("freeze_1", ev(4'hF, 0, 1, 0, 0, 2, 1));
    step("freeze_2", ev(4'hF, 0, 1, 0, 0, 3, 1));
    step("freeze_3", ev(4'hF, 0, 1, 0, 0, 4, 1));
    mem_ready = 1'b1;
    step("mem_ready_release", ev(0, 0, 0, 0, 0, 5, 1));
    mem_req = 1'b0;
    step("ready_without_req", ev(0, 0, 0, 0, 0, 5, 1));
    mem_req = 1'b1;
    step("zero_wait_access", ev(0, 0, 0, 0, 0, 5, 1));
    mem_req   = 1'b0;
    mem_ready = 1'b0;

    // Freeze holds EX (forwarding stays 01); branch pending during MEM_WAIT
    // flushes on the first unfrozen cycle.
    set_id(1, 0, 0, 0, 0, 12, 1, 0);
    step("issue_rd12", ev(0, 0, 0, 0, 0, 5, 1));
    set_id(1, 12, 0, 1, 0, 0, 0, 0);
    mem_req = 1'b1;
    step("freeze_fwd_ex", ev(4'hF, 0, 1, 2'b01, 0, 5, 1));
    ex_br_taken = 1'b1;
    step("branch_in_mem_wait", ev(4'hF, 0, 1, 2'b01, 0, 6, 1));
    mem_ready = 1'b1;
    step("branch_after_ready", ev(0, 2'b11, 0, 2'b01, 0, 7, 1));
    mem_req     = 1'b0;
    mem_ready   = 1'b0;
    ex_br_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step("after_mem_branch", ev(0, 0, 0, 0, 0, 7, 2));

    // x0 writer and an invalid (bubble) writer never forward.
    set_id(1, 0, 0, 0, 0, 0, 1, 0);
    step("issue_x0_writer", ev(0, 0, 0, 0, 0, 7, 2));
    set_id(1, 0, 0, 1, 1, 0, 0, 0);
    step("read_x0", ev(0, 0, 0, 2'b00, 2'b00, 7, 2));
    set_id(0, 0, 0, 0, 0, 13, 1, 0);
    step("issue_invalid_rd13", ev(0, 0, 0, 0, 0, 7, 2));
    set_id(1, 13, 13, 1, 1, 0, 0, 0);
    step("no_fwd_from_invalid", ev(0, 0, 0, 2'b00, 2'b00, 7, 2));

    // Long freeze drives stall_cnt into saturation (4-bit -> 15).
    set_id(1, 0, 0, 0, 0, 14, 1, 0);
    step("issue_rd14", ev(0, 0, 0, 0, 0, 7, 2));
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e_sc = (7 + i > 15) ? 15 : 7 + i;
      step($sformatf("sat_freeze_%0d", i), ev(4'hF, 0, 1, 0, 0, CW'(e_sc), 2));
    end

    // Asynchronous reset in the middle of MEM_WAIT.
    expect_now("frozen_before_reset", ev(4'hF, 0, 1, 0, 0, 15, 2));
    cpu_rst = 1'b0;
    expect_now("async_reset_outputs", ev(0, 0, 0, 0, 0, 0, 0));
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    mem_req = 1'b0;
    set_id(1, 14, 0, 1, 0, 0, 0, 0);
    // Still in MEM_WAIT with mem_ready low would freeze; the rd14 slot
    // surviving reset would forward.
    step("run_after_reset", ev(0, 0, 0, 2'b00, 0, 0, 0));
    mem_req   = 1'b1;
    mem_ready = 1'b1;
    step("zero_wait_after_reset", ev(0, 0, 0, 2'b00, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
